// File: rtl/fig_04c_operand_select.sv
// Operand-select front end: folds TO/WITH/FROM/ALT prefix bytes into prefix
// state and, on each executable opcode, registers the two source operands,
// the destination index, the opcode and its ALT mode for the execute stage.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   op_valid  opcode strobe, one byte per asserted cycle
//   opcode    instruction byte
//   flush     synchronous prefix cancel, overrides op_valid
//   rfile     register file read bus, R(n) = rfile[16n+15:16n]
//   exec      one-cycle pulse for a decoded non-prefix instruction
//   x, y      operands R(source) and R(opcode[3:0]) captured at execute
//   zsel      destination register index
//   op_out    executed opcode
//   alt_out   ALT mode applied to the executed opcode
//   sreg      current source prefix register
//   dreg      current destination prefix register
//   b_flag    WITH prefix pending
module fig_04c_operand_select (
    input  logic         clk,
    input  logic         reset,
    input  logic         op_valid,
    input  logic [7:0]   opcode,
    input  logic         flush,
    input  logic [255:0] rfile,
    output logic         exec,
    output logic [15:0]  x,
    output logic [15:0]  y,
    output logic [3:0]   zsel,
    output logic [7:0]   op_out,
    output logic [1:0]   alt_out,
    output logic [3:0]   sreg,
    output logic [3:0]   dreg,
    output logic         b_flag
);

    localparam int unsigned OP_W  = 8;
    localparam int unsigned REG_W = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned NREG  = 16;
    localparam int unsigned ALT_W = 2;
    localparam int unsigned RF_W  = NREG * REG_W;

    localparam logic [IDX_W-1:0] GRP_TO   = 4'h1;
    localparam logic [IDX_W-1:0] GRP_WITH = 4'h2;
    localparam logic [IDX_W-1:0] GRP_FROM = 4'hB;
    localparam logic [OP_W-1:0]  OP_ALT1  = 8'h3D;
    localparam logic [OP_W-1:0]  OP_ALT2  = 8'h3E;
    localparam logic [OP_W-1:0]  OP_ALT3  = 8'h3F;

    // Prefix state
    logic [IDX_W-1:0] sreg_q, dreg_q;
    logic             b_q;
    logic [ALT_W-1:0] alt_q;

    logic [IDX_W-1:0] sreg_nxt, dreg_nxt;
    logic             b_nxt;
    logic [ALT_W-1:0] alt_nxt;

    // Execute-side selects
    logic             exec_nxt;
    logic [IDX_W-1:0] xsel_nxt;
    logic [IDX_W-1:0] zsel_nxt;

    logic [IDX_W-1:0] grp;
    logic [IDX_W-1:0] n;
    logic             is_to, is_with, is_from, is_alt;

    function automatic logic [REG_W-1:0] reg_read(input logic [RF_W-1:0] rf,
                                                   input logic [IDX_W-1:0] idx);
        return rf[REG_W*idx +: REG_W];
    endfunction

    assign grp     = opcode[7:4];
    assign n       = opcode[3:0];
    assign is_to   = (grp == GRP_TO);
    assign is_with = (grp == GRP_WITH);
    assign is_from = (grp == GRP_FROM);
    assign is_alt  = (opcode == OP_ALT1) || (opcode == OP_ALT2) || (opcode == OP_ALT3);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg_q <= '0;
            dreg_q <= '0;
            b_q    <= 1'b0;
            alt_q  <= '0;
        end else begin
            sreg_q <= sreg_nxt;
            dreg_q <= dreg_nxt;
            b_q    <= b_nxt;
            alt_q  <= alt_nxt;
        end
    end

    // Decode: prefix bytes update state, anything else executes and clears it.
    // TO/FROM only act as prefixes while no WITH is pending; with one pending
    // they become MOVE/MOVES and redirect the destination/source selects.
    always_comb begin
        sreg_nxt = sreg_q;
        dreg_nxt = dreg_q;
        b_nxt    = b_q;
        alt_nxt  = alt_q;
        exec_nxt = 1'b0;
        xsel_nxt = sreg_q;
        zsel_nxt = dreg_q;

        if (flush) begin
            sreg_nxt = '0;
            dreg_nxt = '0;
            b_nxt    = 1'b0;
            alt_nxt  = '0;
        end else if (op_valid) begin
            if (is_with) begin
                sreg_nxt = n;
                dreg_nxt = n;
                b_nxt    = 1'b1;
            end else if (is_to && !b_q) begin
                dreg_nxt = n;
            end else if (is_from && !b_q) begin
                sreg_nxt = n;
            end else if (is_alt) begin
                alt_nxt = opcode[1:0];
            end else begin
                exec_nxt = 1'b1;
                sreg_nxt = '0;
                dreg_nxt = '0;
                b_nxt    = 1'b0;
                alt_nxt  = '0;
                if (is_from) xsel_nxt = n;
                if (is_to)   zsel_nxt = n;
            end
        end
    end

    // Execute outputs: loaded only on exec, otherwise hold last values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exec    <= 1'b0;
            x       <= '0;
            y       <= '0;
            zsel    <= '0;
            op_out  <= '0;
            alt_out <= '0;
        end else begin
            exec <= exec_nxt;
            if (exec_nxt) begin
                x       <= reg_read(rfile, xsel_nxt);
                y       <= reg_read(rfile, n);
                zsel    <= zsel_nxt;
                op_out  <= opcode;
                alt_out <= alt_q;
            end
        end
    end

    assign sreg   = sreg_q;
    assign dreg   = dreg_q;
    assign b_flag = b_q;

endmodule

// File: tb/tb_fig_04c_operand_select.sv
// Bench for fig_04c_operand_select: hand-derived vector table, reset corner
// sequence, then a random stream checked against a small reference model.
module tb_fig_04c_operand_select;

    logic         clk;
    logic         reset;
    logic         op_valid;
    logic [7:0]   opcode;
    logic         flush;
    logic [255:0] rfile;
    logic         exec;
    logic [15:0]  x, y;
    logic [3:0]   zsel;
    logic [7:0]   op_out;
    logic [1:0]   alt_out;
    logic [3:0]   sreg, dreg;
    logic         b_flag;

    logic [15:0] rarr [16];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [3:0]  zsel;
        logic [7:0]  op;
        logic [1:0]  alt;
    } exp_t;

    typedef struct {
        logic       v;
        logic [7:0] op;
        logic       fl;
        logic       e;
        logic [3:0] xi;
        logic [3:0] z;
        logic [1:0] al;
        logic [3:0] s;
        logic [3:0] d;
        logic       b;
    } vec_t;

    exp_t exp_q[$];
    exp_t last;
    vec_t vecs[$];

    // Reference model state for the random phase
    logic [3:0] m_s, m_d;
    logic       m_b;
    logic [1:0] m_alt;

    fig_04c_operand_select dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .opcode(opcode),
        .flush(flush), .rfile(rfile), .exec(exec), .x(x), .y(y),
        .zsel(zsel), .op_out(op_out), .alt_out(alt_out),
        .sreg(sreg), .dreg(dreg), .b_flag(b_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 16; i++) rfile[i*16 +: 16] = rarr[i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] op, input logic fl, input logic e,
                       input logic [3:0] xi, input logic [3:0] z, input logic [1:0] al,
                       input logic [3:0] s, input logic [3:0] d, input logic b);
        vec_t t;
        t.v = v; t.op = op; t.fl = fl; t.e = e; t.xi = xi; t.z = z; t.al = al;
        t.s = s; t.d = d; t.b = b;
        vecs.push_back(t);
    endtask

    // Drive one cycle from a negedge, sample 1 time unit after the posedge.
    task automatic apply(input logic v, input logic [7:0] op, input logic fl, input logic e,
                         input logic [3:0] xi, input logic [3:0] z, input logic [1:0] al,
                         input logic [3:0] s, input logic [3:0] d, input logic b);
        exp_t r;
        op_valid = v;
        opcode   = op;
        flush    = fl;
        if (e) begin
            r.x = rarr[xi]; r.y = rarr[op[3:0]]; r.zsel = z; r.op = op; r.alt = al;
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        chk("exec", 32'(exec), 32'(e));
        chk("sreg", 32'(sreg), 32'(s));
        chk("dreg", 32'(dreg), 32'(d));
        chk("b_flag", 32'(b_flag), 32'(b));
        if (exec) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_exec", 32'(exec), 32'd0);
            end else begin
                r = exp_q.pop_front();
                chk("x", 32'(x), 32'(r.x));
                chk("y", 32'(y), 32'(r.y));
                chk("zsel", 32'(zsel), 32'(r.zsel));
                chk("op_out", 32'(op_out), 32'(r.op));
                chk("alt_out", 32'(alt_out), 32'(r.alt));
                last = r;
            end
        end else begin
            if (e && exp_q.size() != 0) void'(exp_q.pop_front());
            chk("hold_x", 32'(x), 32'(last.x));
            chk("hold_zsel", 32'(zsel), 32'(last.zsel));
            chk("hold_op_out", 32'(op_out), 32'(last.op));
            chk("hold_alt_out", 32'(alt_out), 32'(last.alt));
        end
        @(negedge clk);
        op_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_exec"}, 32'(exec), 32'd0);
        chk({tag, "_x"}, 32'(x), 32'd0);
        chk({tag, "_y"}, 32'(y), 32'd0);
        chk({tag, "_zsel"}, 32'(zsel), 32'd0);
        chk({tag, "_op_out"}, 32'(op_out), 32'd0);
        chk({tag, "_alt_out"}, 32'(alt_out), 32'd0);
        chk({tag, "_sreg"}, 32'(sreg), 32'd0);
        chk({tag, "_dreg"}, 32'(dreg), 32'd0);
        chk({tag, "_b_flag"}, 32'(b_flag), 32'd0);
    endtask

    // Spec-level model of one opcode; computes expectations then applies them
    task automatic model_step(input logic v, input logic [7:0] op, input logic fl);
        logic       e;
        logic [3:0] xi, z, hi, nn;
        logic [1:0] al;
        e = 1'b0; xi = m_s; z = m_d; al = m_alt;
        hi = op[7:4]; nn = op[3:0];
        if (fl) begin
            m_s = 0; m_d = 0; m_b = 0; m_alt = 0;
        end else if (v) begin
            if (hi == 4'h2) begin
                m_s = nn; m_d = nn; m_b = 1'b1;
            end else if (hi == 4'h1 && !m_b) begin
                m_d = nn;
            end else if (hi == 4'hB && !m_b) begin
                m_s = nn;
            end else if (op == 8'h3D) begin
                m_alt = 2'b01;
            end else if (op == 8'h3E) begin
                m_alt = 2'b10;
            end else if (op == 8'h3F) begin
                m_alt = 2'b11;
            end else begin
                e = 1'b1;
                if (hi == 4'hB) xi = nn;
                if (hi == 4'h1) z = nn;
                m_s = 0; m_d = 0; m_b = 0; m_alt = 0;
            end
        end
        apply(v, op, fl, e, xi, z, al, m_s, m_d, m_b);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rarr[i] = 16'hA000 | 16'(i * 16'h0111);
        rarr[2] = 16'hBEEF;
        rarr[3] = 16'h1234;
        rarr[5] = 16'h00FF;
        last = '{x: 16'h0, y: 16'h0, zsel: 4'h0, op: 8'h0, alt: 2'h0};

        reset = 1'b0; op_valid = 1'b0; opcode = 8'h00; flush = 1'b0;
        #1;
        chk_all_zero("por");
        @(posedge clk); @(posedge clk); #1;
        chk_all_zero("por_held");
        @(negedge clk);
        reset = 1'b1;

        //  v  op    fl e  xi  z   al  s   d   b
        add(1, 8'h13, 0, 0, 0,  0,  0, 0,  3,  0);   // TO R3
        add(1, 8'hB5, 0, 0, 0,  0,  0, 5,  3,  0);   // FROM R5
        add(1, 8'h57, 0, 1, 5,  3,  0, 0,  0,  0);   // exec x=R5 z=3
        add(1, 8'h24, 0, 0, 0,  0,  0, 4,  4,  1);   // WITH R4
        add(1, 8'h12, 0, 1, 4,  2,  0, 0,  0,  0);   // MOVE
        add(1, 8'h24, 0, 0, 0,  0,  0, 4,  4,  1);
        add(1, 8'hB2, 0, 1, 2,  4,  0, 0,  0,  0);   // MOVES x=0xBEEF
        add(1, 8'h3E, 0, 0, 0,  0,  0, 0,  0,  0);   // ALT2
        add(1, 8'h16, 0, 0, 0,  0,  0, 0,  6,  0);
        add(1, 8'h50, 0, 1, 0,  6,  2, 0,  0,  0);
        add(1, 8'h50, 0, 1, 0,  0,  0, 0,  0,  0);
        add(1, 8'h19, 0, 0, 0,  0,  0, 0,  9,  0);
        add(1, 8'h60, 1, 0, 0,  0,  0, 0,  0,  0);   // flush beats op_valid
        add(1, 8'h60, 0, 1, 0,  0,  0, 0,  0,  0);
        add(0, 8'h77, 0, 0, 0,  0,  0, 0,  0,  0);   // idle, outputs hold
        add(1, 8'h3F, 0, 0, 0,  0,  0, 0,  0,  0);   // ALT3
        add(1, 8'hB7, 0, 0, 0,  0,  0, 7,  0,  0);
        add(1, 8'h01, 0, 1, 7,  0,  3, 0,  0,  0);   // NOP
        add(1, 8'h2C, 0, 0, 0,  0,  0, 12, 12, 1);
        add(0, 8'h00, 1, 0, 0,  0,  0, 0,  0,  0);   // lone flush
        add(1, 8'h2A, 0, 0, 0,  0,  0, 10, 10, 1);
        add(1, 8'h3D, 0, 0, 0,  0,  0, 10, 10, 1);   // ALT1 keeps prefix
        add(1, 8'h1F, 0, 1, 10, 15, 1, 0,  0,  0);   // MOVE with ALT1
        add(1, 8'h23, 0, 0, 0,  0,  0, 3,  3,  1);
        add(1, 8'h25, 0, 0, 0,  0,  0, 5,  5,  1);   // WITH overrides WITH
        add(1, 8'hB9, 0, 1, 9,  5,  0, 0,  0,  0);   // MOVES

        @(negedge clk);
        foreach (vecs[i])
            apply(vecs[i].v, vecs[i].op, vecs[i].fl, vecs[i].e, vecs[i].xi,
                  vecs[i].z, vecs[i].al, vecs[i].s, vecs[i].d, vecs[i].b);

        // Reset in the middle of a WITH prefix; opcode presented during reset
        apply(1, 8'h2A, 0, 0, 0, 0, 0, 10, 10, 1);
        reset = 1'b0;
        op_valid = 1'b1;
        opcode = 8'h57;
        #1;
        chk_all_zero("in_reset");
        @(posedge clk); @(posedge clk); #1;
        chk_all_zero("in_reset_held");
        @(negedge clk);
        op_valid = 1'b0;
        reset = 1'b1;
        last = '{x: 16'h0, y: 16'h0, zsel: 4'h0, op: 8'h0, alt: 2'h0};
        apply(1, 8'h11, 0, 0, 0, 0, 0, 0, 1, 0);     // TO, prefix discarded
        apply(1, 8'h57, 0, 1, 0, 1, 0, 0, 0, 0);

        // Random stream against the reference model
        m_s = 0; m_d = 0; m_b = 0; m_alt = 0;
        for (int k = 0; k < 400; k++) begin
            logic [7:0] op;
            logic       v, fl;
            int         cat;
            rarr[$urandom_range(15)] = 16'($urandom);
            cat = int'($urandom_range(7));
            case (cat)
                0: op = 8'h10 | 8'($urandom_range(15));
                1: op = 8'h20 | 8'($urandom_range(15));
                2: op = 8'hB0 | 8'($urandom_range(15));
                3: op = 8'h3D + 8'($urandom_range(2));
                default: op = 8'($urandom);
            endcase
            v  = ($urandom_range(3) != 0);
            fl = ($urandom_range(9) == 0);
            model_step(v, op, fl);
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule

// File: doc/fig_04c_operand_select.md
FIG_04C_OPERAND_SELECT -- requirements
Module: fig_04c_operand_select

Interface
REQ-001 The block SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 The block SHALL have ports: reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 The block SHALL have ports: op_valid  in  1  opcode strobe, one opcode byte per asserted cycle.
REQ-004 The block SHALL have ports: opcode  in  8  instruction byte, sampled when op_valid=1.
REQ-005 The block SHALL have ports: flush  in  1  synchronous prefix cancel (branch taken / pipeline flush).
REQ-006 The block SHALL have ports: rfile  in  256  register file read bus; R(n) = rfile[16n+15:16n], n=0..15.
REQ-007 The block SHALL have ports: exec  out  1  one-cycle pulse marking a decoded non-prefix instruction.
REQ-008 The block SHALL have ports: x  out  16  source operand R(sreg) captured at execute.
REQ-009 The block SHALL have ports: y  out  16  operand R(opcode[3:0]) captured at execute.
REQ-010 The block SHALL have ports: zsel  out  4  destination register index for the register-file write side.
REQ-011 The block SHALL have ports: op_out  out  8  executed opcode; alt_out  out  2  ALT mode applied to it.
REQ-012 The block SHALL have ports: sreg, dreg  out  4 each  current prefix state; b_flag  out  1  WITH prefix pending.

Function
REQ-013 Internal state SHALL be sreg[3:0], dreg[3:0], b_flag, alt[1:0]; sreg/dreg/b_flag are driven directly from this state.
REQ-014 With op_valid=0 and flush=0, all state SHALL hold and exec SHALL be 0 next cycle.
REQ-015 TO (0x10-0x1F, n=opcode[3:0]) with b_flag=0: dreg<=n; no exec; other state held.
REQ-016 TO with b_flag=1 (MOVE): exec, zsel=n, x=R(sreg); prefix state cleared.
REQ-017 WITH (0x20-0x2F): sreg<=n, dreg<=n, b_flag<=1; no exec.
REQ-018 FROM (0xB0-0xBF) with b_flag=0: sreg<=n; no exec.
REQ-019 FROM with b_flag=1 (MOVES): exec, zsel=dreg, x=R(n); prefix state cleared.
REQ-020 ALT1 0x3D: alt<=2'b01; ALT2 0x3E: alt<=2'b10; ALT3 0x3F: alt<=2'b11; no exec; sreg/dreg/b_flag held.
REQ-021 Any other opcode (including NOP 0x01): exec, x=R(sreg), y=R(opcode[3:0]), zsel=dreg, alt_out=alt.
REQ-022 Every exec SHALL clear prefix state: sreg<=0, dreg<=0, b_flag<=0, alt<=0, same edge as outputs load.
REQ-023 Latency: exec, x, y, zsel, op_out, alt_out registered; valid exactly one cycle after the op_valid edge; rfile sampled on that edge.
REQ-024 x, y, zsel, op_out, alt_out SHALL hold their last executed values while exec=0.
REQ-025 For MOVE/MOVES, y SHALL be R(opcode[3:0]) and alt_out SHALL be current alt, same as REQ-021.
REQ-026 flush=1 SHALL clear prefix state to zero and suppress exec for any coincident op_valid; flush has priority.
REQ-027 Back-to-back op_valid SHALL be supported at one opcode per cycle; each opcode sees state updated by its predecessor.

Reset
REQ-028 On reset=0, asynchronously: sreg=0, dreg=0, b_flag=0, alt=0, exec=0, x=0, y=0, zsel=0, op_out=0, alt_out=0.
REQ-029 Reset asserted mid-prefix sequence SHALL discard the prefix; first opcode after release decodes with R0/R0 defaults.
REQ-030 Release of reset SHALL take effect at the next rising clk edge; no opcode is accepted during reset.

Verification
REQ-031 R3=0x1234, R5=0x00FF; opcodes 0x13 (TO R3), 0xB5 (FROM R5), 0x57 -> exec one cycle after 0x57, zsel=3, x=0x00FF, y=R7, sreg=dreg=0 afterwards.
REQ-032 R2=0xBEEF; opcodes 0x24 (WITH R4), 0x12 -> MOVE: exec, zsel=2, x=R4; b_flag=0 after; then 0x24, 0xB2 -> MOVES: zsel=4, x=0xBEEF.
REQ-033 Opcodes 0x3E, 0x16, 0x50 -> alt_out=2'b10, zsel=6; following 0x50 -> alt_out=0, zsel=0.
REQ-034 Opcodes 0x19, then 0x60 with flush=1 same cycle -> exec stays 0, dreg=0; next 0x60 -> zsel=0.
REQ-035 Opcode 0x2A then reset=0 for 2 cycles, release, opcode 0x11 -> b_flag=0 so no exec, dreg=1; all outputs read 0 during reset.
